// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared ISA constants for the 16-bit teaching CPU: field widths, the opcode
// encoding and the control-bundle type produced by the opcode enable table.
// Ports: none (package).
// ---------------------------------------------------------------------------
package decoder_pkg;

   localparam int INST_W = 16;
   localparam int OP_W   = 4;
   localparam int SEL_W  = 3;
   localparam int IMM_W  = 9;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 4'h0,
      OP_ADD   = 4'h1,
      OP_SUB   = 4'h2,
      OP_AND   = 4'h3,
      OP_OR    = 4'h4,
      OP_XOR   = 4'h5,
      OP_NOT   = 4'h6,
      OP_MOV   = 4'h7,
      OP_LOADI = 4'h8
   } opcode_t;

   // legal is low for reserved opcodes so the top can squash them to NOP.
   typedef struct packed {
      logic legal;
      logic lout;
      logic rout;
      logic oin;
      logic uses_imm;
      logic uses_rsel;
   } ctl_t;

endpackage

// File: rtl/decoder_ctl.sv
// ---------------------------------------------------------------------------
// decoder_ctl
// Combinational opcode-indexed enable table.
// Ports:
//   i_op  : 4-bit opcode field of the instruction
//   o_ctl : control bundle {legal, lout, rout, oin, uses_imm, uses_rsel}
// ---------------------------------------------------------------------------
module decoder_ctl
   import decoder_pkg::*;
(
   input  logic [OP_W-1:0] i_op,
   output ctl_t            o_ctl
);

   // Reserved opcodes fall through to the all-zero default so they can
   // never raise a register write enable.
   always_comb begin
      o_ctl = '0;
      case (i_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            o_ctl.legal     = 1'b1;
            o_ctl.lout      = 1'b1;
            o_ctl.rout      = 1'b1;
            o_ctl.oin       = 1'b1;
            o_ctl.uses_rsel = 1'b1;
         end
         OP_NOT, OP_MOV: begin
            o_ctl.legal = 1'b1;
            o_ctl.lout  = 1'b1;
            o_ctl.oin   = 1'b1;
         end
         OP_LOADI: begin
            o_ctl.legal    = 1'b1;
            o_ctl.oin      = 1'b1;
            o_ctl.uses_imm = 1'b1;
         end
         OP_NOP: begin
            o_ctl.legal = 1'b1;
         end
         default: begin
            o_ctl = '0;
         end
      endcase
   end

endmodule

// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
// Instruction decoder: latches one instruction word per clock and drives the
// registered control fields for the register file, ALU and immediate bus.
// Latency one cycle, one instruction per cycle, no multi-cycle state.
// Ports:
//   clk  : system clock, rising edge
//   res  : asynchronous active-low reset, clears every output
//   INST : 16-bit instruction word
//   OP   : opcode to the ALU (NOP for reserved opcodes)
//   LSEL : left-operand register select
//   RSEL : right-operand register select
//   OSEL : destination register select
//   LOUT : left register drives its operand bus
//   ROUT : right register drives its operand bus
//   OIN  : destination register write enable
//   Rbus : zero-extended immediate, 0 when no immediate
// ---------------------------------------------------------------------------
module decoder
   import decoder_pkg::*;
(
   input  logic              clk,
   input  logic              res,
   input  logic [INST_W-1:0] INST,
   output logic [OP_W-1:0]   OP,
   output logic [SEL_W-1:0]  LSEL,
   output logic [SEL_W-1:0]  RSEL,
   output logic [SEL_W-1:0]  OSEL,
   output logic              LOUT,
   output logic              ROUT,
   output logic              OIN,
   output logic [INST_W-1:0] Rbus
);

   logic [OP_W-1:0]   w_op;
   logic [SEL_W-1:0]  w_dst;
   logic [SEL_W-1:0]  w_src_l;
   logic [SEL_W-1:0]  w_src_r;
   logic [IMM_W-1:0]  w_imm9;
   logic              w_unused_bits;
   ctl_t              w_ctl;

   logic [OP_W-1:0]   w_op_next;
   logic [SEL_W-1:0]  w_lsel_next;
   logic [SEL_W-1:0]  w_rsel_next;
   logic [SEL_W-1:0]  w_osel_next;
   logic [INST_W-1:0] w_rbus_next;

   logic [OP_W-1:0]   r_op;
   logic [SEL_W-1:0]  r_lsel;
   logic [SEL_W-1:0]  r_rsel;
   logic [SEL_W-1:0]  r_osel;
   logic              r_lout;
   logic              r_rout;
   logic              r_oin;
   logic [INST_W-1:0] r_rbus;

   // imm9 overlaps src_l and src_r; which one matters depends on the opcode.
   assign w_op          = INST[15:12];
   assign w_dst         = INST[11:9];
   assign w_src_l       = INST[8:6];
   assign w_src_r       = INST[5:3];
   assign w_imm9        = INST[8:0];
   assign w_unused_bits = ^INST[2:0];

   decoder_ctl u_ctl (
      .i_op  (w_op),
      .o_ctl (w_ctl)
   );

   // Fields an opcode does not use are forced to zero so downstream logic
   // sees clean selects rather than stray instruction bits.
   assign w_op_next   = w_ctl.legal     ? w_op               : OP_NOP;
   assign w_osel_next = w_ctl.oin       ? w_dst              : '0;
   assign w_lsel_next = w_ctl.lout      ? w_src_l            : '0;
   assign w_rsel_next = w_ctl.uses_rsel ? w_src_r            : '0;
   assign w_rbus_next = w_ctl.uses_imm  ? {7'b0, w_imm9}     : '0;

   // Output registers; reset clears immediately and discards the in-flight
   // decode, the first edge after release loads the current INST.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_op   <= '0;
         r_lsel <= '0;
         r_rsel <= '0;
         r_osel <= '0;
         r_lout <= 1'b0;
         r_rout <= 1'b0;
         r_oin  <= 1'b0;
         r_rbus <= '0;
      end else begin
         r_op   <= w_op_next;
         r_lsel <= w_lsel_next;
         r_rsel <= w_rsel_next;
         r_osel <= w_osel_next;
         r_lout <= w_ctl.lout;
         r_rout <= w_ctl.rout;
         r_oin  <= w_ctl.oin;
         r_rbus <= w_rbus_next;
      end
   end

   assign OP   = r_op;
   assign LSEL = r_lsel;
   assign RSEL = r_rsel;
   assign OSEL = r_osel;
   assign LOUT = r_lout;
   assign ROUT = r_rout;
   assign OIN  = r_oin;
   assign Rbus = r_rbus;

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder
// Self-checking bench for decoder: directed instruction sequence, expected
// decodes pushed to a scoreboard queue and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_decoder;

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  lsel;
      logic [2:0]  rsel;
      logic [2:0]  osel;
      logic        lout;
      logic        rout;
      logic        oin;
      logic [15:0] rbus;
   } dec_t;

   logic        clk;
   logic        res;
   logic [15:0] INST;
   logic [3:0]  OP;
   logic [2:0]  LSEL;
   logic [2:0]  RSEL;
   logic [2:0]  OSEL;
   logic        LOUT;
   logic        ROUT;
   logic        OIN;
   logic [15:0] Rbus;

   int   checks;
   int   failures;
   dec_t sb[$];
   dec_t lastExp;

   decoder dut (
      .clk  (clk),
      .res  (res),
      .INST (INST),
      .OP   (OP),
      .LSEL (LSEL),
      .RSEL (RSEL),
      .OSEL (OSEL),
      .LOUT (LOUT),
      .ROUT (ROUT),
      .OIN  (OIN),
      .Rbus (Rbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode written straight from the ISA table.
   function automatic dec_t decodeModel(input logic [15:0] inst);
      dec_t d;
      d = '0;
      case (inst[15:12])
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            d.op   = inst[15:12];
            d.osel = inst[11:9];
            d.lsel = inst[8:6];
            d.rsel = inst[5:3];
            d.lout = 1'b1;
            d.rout = 1'b1;
            d.oin  = 1'b1;
         end
         4'h6, 4'h7: begin
            d.op   = inst[15:12];
            d.osel = inst[11:9];
            d.lsel = inst[8:6];
            d.lout = 1'b1;
            d.oin  = 1'b1;
         end
         4'h8: begin
            d.op   = 4'h8;
            d.osel = inst[11:9];
            d.oin  = 1'b1;
            d.rbus = {7'b0, inst[8:0]};
         end
         default: d = '0;
      endcase
      return d;
   endfunction

   task automatic compareAll(input string tag, input dec_t e);
      checks += 8;
      assert (OP === e.op) else begin
         failures++;
         $error("FAIL %s OP got=%h exp=%h", tag, OP, e.op);
      end
      assert (LSEL === e.lsel) else begin
         failures++;
         $error("FAIL %s LSEL got=%h exp=%h", tag, LSEL, e.lsel);
      end
      assert (RSEL === e.rsel) else begin
         failures++;
         $error("FAIL %s RSEL got=%h exp=%h", tag, RSEL, e.rsel);
      end
      assert (OSEL === e.osel) else begin
         failures++;
         $error("FAIL %s OSEL got=%h exp=%h", tag, OSEL, e.osel);
      end
      assert (LOUT === e.lout) else begin
         failures++;
         $error("FAIL %s LOUT got=%b exp=%b", tag, LOUT, e.lout);
      end
      assert (ROUT === e.rout) else begin
         failures++;
         $error("FAIL %s ROUT got=%b exp=%b", tag, ROUT, e.rout);
      end
      assert (OIN === e.oin) else begin
         failures++;
         $error("FAIL %s OIN got=%b exp=%b", tag, OIN, e.oin);
      end
      assert (Rbus === e.rbus) else begin
         failures++;
         $error("FAIL %s Rbus got=%h exp=%h", tag, Rbus, e.rbus);
      end
   endtask

   // Drive a new instruction away from the active edge and record the
   // decode it must produce (all zero while reset is held).
   task automatic applyStimulus(input logic [15:0] inst);
      @(negedge clk);
      INST = inst;
      if (res) sb.push_back(decodeModel(inst));
      else     sb.push_back('0);
   endtask

   // Sample just after the active edge and compare against the oldest entry.
   task automatic checkOutput(input string tag);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s scoreboard empty got OP=%h exp=entry", tag, OP);
      end else begin
         lastExp = sb.pop_front();
         compareAll(tag, lastExp);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      res      = 1'b0;
      INST     = 16'h8206;

      // Reset held across several edges with a LOADI waiting on INST.
      #1;
      compareAll("reset_async", '0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(16'h8206);
         checkOutput("reset_hold");
      end

      // Release between edges: first edge loads the pending LOADI.
      @(negedge clk);
      res = 1'b1;
      sb.push_back(decodeModel(INST));
      checkOutput("reset_release");

      applyStimulus(16'h8403); checkOutput("loadi_r2_3");
      applyStimulus(16'h1650); checkOutput("add_r3_r1_r2");
      applyStimulus(16'h26C8); checkOutput("sub_r3_r3_r1");
      applyStimulus(16'hF6C8); checkOutput("reserved_F");
      applyStimulus(16'h7640); checkOutput("mov_r3_r1");
      applyStimulus(16'h3FF8); checkOutput("and_all_ones");
      applyStimulus(16'h4A98); checkOutput("or_mixed");
      applyStimulus(16'h5E38); checkOutput("xor_mixed");
      applyStimulus(16'h6BFF); checkOutput("not_stray_bits");
      applyStimulus(16'h8FFF); checkOutput("loadi_max_imm");
      applyStimulus(16'h0FFF); checkOutput("nop_stray_bits");
      applyStimulus(16'h9FFF); checkOutput("reserved_9");

      // INST changing between edges must not disturb registered outputs.
      applyStimulus(16'h1650); checkOutput("add_before_glitch");
      INST = 16'h8FFF;
      #2;
      compareAll("inst_change_mid_cycle", lastExp);

      // Async reset mid-cycle while ADD is decoded.
      applyStimulus(16'h1650); checkOutput("add_before_reset");
      #2;
      res = 1'b0;
      #1;
      compareAll("reset_mid_cycle", '0);
      @(negedge clk);
      INST = 16'h26C8;
      res  = 1'b1;
      sb.push_back(decodeModel(INST));
      checkOutput("resume_after_reset");

      applyStimulus(16'h8001); checkOutput("loadi_r0_1");

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
